decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered RV32I decode stage that sits between instruction fetch and register read/execute.
- Decodes one 32-bit instruction per accepted transfer into a one-hot op vector, register indices, register-usage flags and a sign-extended immediate for the instruction's format.
- Detects illegal encodings and counts them.
- Uses valid/ready handshakes on both sides, with a 2-entry skid buffer so that in_ready is a registered signal, plus a flush input for branch/trap redirects.

Parameters:
- PC_W, 32, width of the PC carried alongside each instruction.
- ENABLE_CSR, 1, when 1 Zicsr ops decode; when 0 they are illegal.
- CNT_W, 16, width of the saturating illegal-instruction counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  stage can accept.
- in_pc  input  PC_W  PC of the instruction.
- in_instr  input  32  raw instruction.
- out_valid  output  1  decoded instruction available.
- out_ready  input  1  downstream accepts.
- out_pc  output  PC_W  PC of the decoded instruction.
- inst_flags  output  48  one-hot op vector; all zero when illegal.
- rd, rs1, rs2  output  5 each  register fields.
- rd_we  output  1  op writes rd, and rd != 0.
- rs1_used, rs2_used  output  1 each  op reads the register.
- imm  output  32  sign-extended immediate for the format; zero for R-type.
- illegal  output  1  illegal encoding.
- flush  input  1  discard all held and incoming instructions.
- cnt_clr  input  1  synchronous clear of illegal_cnt.
- illegal_cnt  output  CNT_W  saturating count of accepted illegal instructions.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, skid empty, in_ready=1, illegal_cnt=0, all data outputs 0. Reset mid-transfer drops everything.
- Acceptance:
  - Input accepted when in_valid && in_ready.
  - Output consumed when out_valid && out_ready.
  - Latency: an instruction accepted at cycle N appears on the outputs at cycle N+1.
- Storage and ordering:
  - Two entries: the output register and the skid register.
  - An accept while the output register is empty or being consumed loads the output register directly.
  - Otherwise the accepted instruction goes to the skid register.
  - When the output is consumed and the skid is full, the skid moves to the output register in the same edge.
  - in_ready = !skid_full (registered). Order is strictly FIFO.
- Simultaneous consume + accept with skid full: skid→out; the new input is not accepted because in_ready=0.
- flush=1:
  - Next edge: out_valid=0, skid empty, in_ready=1.
  - Any same-cycle input is dropped and not counted.
  - A same-cycle output consume still counts as completed downstream.
  - flush has priority over all other updates.
- Decode (combinational on in_instr, registered with the entry):
  - opcode=instr[6:0], funct3=[14:12], funct7=[31:25].
  - inst_flags bit order: 0 lui, 1 auipc, 2 jal, 3 jalr, 4 beq, 5 bne, 6 blt, 7 bge, 8 bltu, 9 bgeu, 10 lb, 11 lh, 12 lw, 13 lbu, 14 lhu, 15 sb, 16 sh, 17 sw, 18 addi, 19 slti, 20 sltiu, 21 xori, 22 ori, 23 andi, 24 slli, 25 srli, 26 srai, 27 add, 28 sub, 29 sll, 30 slt, 31 sltu, 32 xor, 33 srl, 34 sra, 35 or, 36 and, 37 fence, 38 ecall, 39 ebreak, 40 csrrw, 41 csrrs, 42 csrrc, 43 csrrwi, 44 csrrsi, 45 csrrci, 46-47 reserved (always 0).
  - Exactly one bit is set for a legal instruction.
- Illegal when any of the following hold:
  - opcode[1:0] != 11, or opcode is unlisted.
  - Unused funct3: branch 010/011; load 011/110/111; store other than 000-010; jalr funct3 != 0; CSR 000/100.
  - R-type funct7 other than 0000000, or 0100000 with add/srl.
  - Shift-immediate funct7 other than 0000000, or 0100000 with srli.
  - SYSTEM funct3=000 with instr[31:7] other than the ecall/ebreak patterns.
  - Zicsr op with ENABLE_CSR=0.
  - On illegal: inst_flags=0, rd_we=0, rs1_used=rs2_used=0, imm=0, illegal=1; the entry still flows downstream.
- Immediate formats:
  - I: instr[31:20], sign-extended.
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0}.
  - CSR ops: imm = zero-extended csr address [31:20]; rs1 field carries uimm for *i forms, and rs1_used=0 for those.
- Counter:
  - Increments by 1 on acceptance of an illegal instruction, unless flushed the same cycle.
  - Saturates at 2^CNT_W-1.
  - cnt_clr sets it to 0 and beats a same-cycle increment.

Test Plan:
- Reset then 0x00500093 (addi x1,x0,5), out_ready=1 → next cycle out_valid=1, inst_flags bit18 only, rd=1, rs1=0, imm=5, rd_we=1, rs2_used=0.
- 0x40208133 (sub) then 0xFE000EE3 (beq x0,x0,-4) back-to-back → bit28 with rs1=1, rs2=2; then bit4 with imm=0xFFFFFFFC, rd_we=0.
- out_ready=0, feed 3 instrs with in_valid=1 → two accepted, in_ready=0 from the cycle after the second accept; release out_ready → outputs appear in order with no loss or duplication.
- 0xFFFFFFFF and 0x00000000 → illegal=1, inst_flags=0, illegal_cnt=2; with CNT_W=2, five illegals → cnt saturates at 3; cnt_clr → 0.
- Both entries full, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1, illegal_cnt unchanged; the next instruction decodes normally.
- ENABLE_CSR=0, 0x30029073 (csrrw) → illegal=1; ENABLE_CSR=1 → bit40, imm=0x300, rs1=5.

Source files
------------

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side stream signals of the RV32I decode stage.
// Valid/ready: a transfer happens on a rising edge where valid && ready; payload is stable while valid waits.
interface decode_stage_if #(
    parameter int PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [PC_W-1:0] in_pc;
    logic [31:0]     in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [47:0]     inst_flags;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            rd_we;
    logic            rs1_used;
    logic            rs2_used;
    logic [31:0]     imm;
    logic            illegal;

    modport master (
        output in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, inst_flags, rd, rs1, rs2,
               rd_we, rs1_used, rs2_used, imm, illegal
    );

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, inst_flags, rd, rs1, rs2,
               rd_we, rs1_used, rs2_used, imm, illegal
    );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: combinational decode into a 2-entry (output + skid) buffer,
// registered in_ready, flush for redirects and a saturating illegal-instruction counter.
module decode_stage #(
    parameter int PC_W       = 32,
    parameter bit ENABLE_CSR = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    decode_stage_if.slave    dif,
    input  logic             flush,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [47:0]     flags;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            rd_we;
        logic            rs1_used;
        logic            rs2_used;
        logic [31:0]     imm;
        logic            illegal;
    } entry_t;

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_csr;

    assign instr   = dif.in_instr;
    assign opcode  = instr[6:0];
    assign funct3  = instr[14:12];
    assign funct7  = instr[31:25];
    assign imm_i   = {{20{instr[31]}}, instr[31:20]};
    assign imm_s   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u   = {instr[31:12], 12'b0};
    assign imm_j   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_csr = {20'b0, instr[31:20]};

    logic        op_ok;
    logic [5:0]  op_idx;
    logic        we, use1, use2;
    logic [31:0] imm_sel;
    entry_t      dec;

    // A legal encoding sets op_ok and exactly one op_idx; anything else leaves op_ok low.
    always_comb begin
        op_ok   = 1'b0;
        op_idx  = '0;
        we      = 1'b0;
        use1    = 1'b0;
        use2    = 1'b0;
        imm_sel = '0;
        case (opcode)
            7'b0110111: begin op_ok = 1'b1; op_idx = 6'd0; we = 1'b1; imm_sel = imm_u; end
            7'b0010111: begin op_ok = 1'b1; op_idx = 6'd1; we = 1'b1; imm_sel = imm_u; end
            7'b1101111: begin op_ok = 1'b1; op_idx = 6'd2; we = 1'b1; imm_sel = imm_j; end
            7'b1100111: begin
                op_ok = (funct3 == 3'b000); op_idx = 6'd3; we = 1'b1; use1 = 1'b1; imm_sel = imm_i;
            end
            7'b1100011: begin
                op_ok = 1'b1; use1 = 1'b1; use2 = 1'b1; imm_sel = imm_b;
                case (funct3)
                    3'b000:  op_idx = 6'd4;
                    3'b001:  op_idx = 6'd5;
                    3'b100:  op_idx = 6'd6;
                    3'b101:  op_idx = 6'd7;
                    3'b110:  op_idx = 6'd8;
                    3'b111:  op_idx = 6'd9;
                    default: op_ok  = 1'b0;
                endcase
            end
            7'b0000011: begin
                op_ok = 1'b1; we = 1'b1; use1 = 1'b1; imm_sel = imm_i;
                case (funct3)
                    3'b000:  op_idx = 6'd10;
                    3'b001:  op_idx = 6'd11;
                    3'b010:  op_idx = 6'd12;
                    3'b100:  op_idx = 6'd13;
                    3'b101:  op_idx = 6'd14;
                    default: op_ok  = 1'b0;
                endcase
            end
            7'b0100011: begin
                op_ok = 1'b1; use1 = 1'b1; use2 = 1'b1; imm_sel = imm_s;
                case (funct3)
                    3'b000:  op_idx = 6'd15;
                    3'b001:  op_idx = 6'd16;
                    3'b010:  op_idx = 6'd17;
                    default: op_ok  = 1'b0;
                endcase
            end
            7'b0010011: begin
                op_ok = 1'b1; we = 1'b1; use1 = 1'b1; imm_sel = imm_i;
                case (funct3)
                    3'b000: op_idx = 6'd18;
                    3'b010: op_idx = 6'd19;
                    3'b011: op_idx = 6'd20;
                    3'b100: op_idx = 6'd21;
                    3'b110: op_idx = 6'd22;
                    3'b111: op_idx = 6'd23;
                    3'b001: begin op_idx = 6'd24; op_ok = (funct7 == 7'b0000000); end
                    default: begin
                        if (funct7 == 7'b0000000)      op_idx = 6'd25;
                        else if (funct7 == 7'b0100000) op_idx = 6'd26;
                        else                           op_ok  = 1'b0;
                    end
                endcase
            end
            7'b0110011: begin
                op_ok = 1'b1; we = 1'b1; use1 = 1'b1; use2 = 1'b1;
                case ({funct7, funct3})
                    10'b0000000_000: op_idx = 6'd27;
                    10'b0100000_000: op_idx = 6'd28;
                    10'b0000000_001: op_idx = 6'd29;
                    10'b0000000_010: op_idx = 6'd30;
                    10'b0000000_011: op_idx = 6'd31;
                    10'b0000000_100: op_idx = 6'd32;
                    10'b0000000_101: op_idx = 6'd33;
                    10'b0100000_101: op_idx = 6'd34;
                    10'b0000000_110: op_idx = 6'd35;
                    10'b0000000_111: op_idx = 6'd36;
                    default:         op_ok  = 1'b0;
                endcase
            end
            7'b0001111: begin op_ok = 1'b1; op_idx = 6'd37; imm_sel = imm_i; end
            7'b1110011: begin
                if (funct3 == 3'b000) begin
                    if (instr[31:7] == 25'h0000000) begin op_ok = 1'b1; op_idx = 6'd38; end
                    else if (instr[31:7] == 25'h0002000) begin op_ok = 1'b1; op_idx = 6'd39; end
                end else begin
                    // Immediate CSR forms reuse the rs1 field as uimm, so rs1 is not read.
                    op_ok   = ENABLE_CSR && (funct3[1:0] != 2'b00);
                    op_idx  = funct3[2] ? 6'd42 + {4'b0, funct3[1:0]} : 6'd39 + {4'b0, funct3[1:0]};
                    we      = 1'b1;
                    use1    = !funct3[2];
                    imm_sel = imm_csr;
                end
            end
            default: op_ok = 1'b0;
        endcase

        dec.pc       = dif.in_pc;
        dec.flags    = op_ok ? (48'd1 << op_idx) : 48'd0;
        dec.rd       = instr[11:7];
        dec.rs1      = instr[19:15];
        dec.rs2      = instr[24:20];
        dec.rd_we    = op_ok && we && (instr[11:7] != 5'd0);
        dec.rs1_used = op_ok && use1;
        dec.rs2_used = op_ok && use2;
        dec.imm      = op_ok ? imm_sel : 32'd0;
        dec.illegal  = !op_ok;
    end

    entry_t           out_q, out_d, skid_q, skid_d;
    logic             out_valid_q, out_valid_d;
    logic             skid_full_q, skid_full_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept, consume;

    assign accept  = dif.in_valid && !skid_full_q;
    assign consume = out_valid_q && dif.out_ready;

    // The skid only fills while the output is held, so draining it never coincides with an accept.
    always_comb begin
        out_d       = out_q;
        skid_d      = skid_q;
        out_valid_d = out_valid_q;
        skid_full_d = skid_full_q;
        if (flush) begin
            out_valid_d = 1'b0;
            skid_full_d = 1'b0;
        end else if (consume) begin
            if (skid_full_q) begin
                out_d       = skid_q;
                skid_full_d = 1'b0;
            end else if (accept) begin
                out_d = dec;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_q) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                skid_d      = dec;
                skid_full_d = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr)
            cnt_d = '0;
        else if (accept && dec.illegal && !flush && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            skid_full_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            out_q       <= out_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            skid_full_q <= skid_full_d;
            cnt_q       <= cnt_d;
        end
    end

    assign dif.in_ready   = !skid_full_q;
    assign dif.out_valid  = out_valid_q;
    assign dif.out_pc     = out_q.pc;
    assign dif.inst_flags = out_q.flags;
    assign dif.rd         = out_q.rd;
    assign dif.rs1        = out_q.rs1;
    assign dif.rs2        = out_q.rs2;
    assign dif.rd_we      = out_q.rd_we;
    assign dif.rs1_used   = out_q.rs1_used;
    assign dif.rs2_used   = out_q.rs2_used;
    assign dif.imm        = out_q.imm;
    assign dif.illegal    = out_q.illegal;
    assign illegal_cnt    = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: dut_a uses defaults, dut_b has CNT_W=2 and Zicsr disabled.
// Directed vectors carry hand-decoded expectations into per-DUT queues popped by output monitors.
module tb_decode_stage;

    typedef logic [130:0] vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_a, cnt_clr_a, flush_b, cnt_clr_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    always #5 clk = ~clk;

    decode_stage_if #(.PC_W(32)) aif ();
    decode_stage_if #(.PC_W(32)) bif ();

    decode_stage #(.PC_W(32), .ENABLE_CSR(1'b1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .dif(aif), .flush(flush_a), .cnt_clr(cnt_clr_a), .illegal_cnt(cnt_a)
    );

    decode_stage #(.PC_W(32), .ENABLE_CSR(1'b0), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .dif(bif), .flush(flush_b), .cnt_clr(cnt_clr_b), .illegal_cnt(cnt_b)
    );

    vec_t exp_a[$];
    vec_t exp_b[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Packs {illegal, flags, rd, rs1, rs2, rd_we, rs1_used, rs2_used, imm, pc}; fbit < 0 means illegal.
    function automatic vec_t mk(input int fbit, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic we, input logic u1, input logic u2,
                                input logic [31:0] imm, input logic [31:0] pc);
        logic [47:0] fl;
        fl = '0;
        if (fbit >= 0) fl[fbit] = 1'b1;
        return {(fbit < 0), fl, rd, rs1, rs2, we, u1, u2, imm, pc};
    endfunction

    task automatic check(input string name, input vec_t act, input vec_t exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n && aif.out_valid && aif.out_ready) begin
            if (exp_a.size() == 0) begin
                n_total++;
                $display("FAIL out_a_unexpected: got pc %h, want no output", aif.out_pc);
            end else begin
                check("out_a", {aif.illegal, aif.inst_flags, aif.rd, aif.rs1, aif.rs2, aif.rd_we,
                                aif.rs1_used, aif.rs2_used, aif.imm, aif.out_pc}, exp_a.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bif.out_valid && bif.out_ready) begin
            if (exp_b.size() == 0) begin
                n_total++;
                $display("FAIL out_b_unexpected: got pc %h, want no output", bif.out_pc);
            end else begin
                check("out_b", {bif.illegal, bif.inst_flags, bif.rd, bif.rs1, bif.rs2, bif.rd_we,
                                bif.rs1_used, bif.rs2_used, bif.imm, bif.out_pc}, exp_b.pop_front());
            end
        end
    end

    task automatic drive_in(input bit b, input logic v, input logic [31:0] instr,
                            input logic [31:0] pc, input logic fl);
        if (b) begin
            bif.in_valid = v; bif.in_instr = instr; bif.in_pc = pc; flush_b = fl;
        end else begin
            aif.in_valid = v; aif.in_instr = instr; aif.in_pc = pc; flush_a = fl;
        end
    endtask

    // One cycle of in_valid; entered and left just after a rising edge.
    task automatic offer(input bit b, input logic [31:0] instr, input logic [31:0] pc,
                         input vec_t exp, input logic fl, output bit acc);
        drive_in(b, 1'b1, instr, pc, fl);
        @(negedge clk);
        acc = (b ? bif.in_ready : aif.in_ready) && !fl;
        if (acc) begin
            if (b) exp_b.push_back(exp);
            else   exp_a.push_back(exp);
        end
        @(posedge clk); #1;
        drive_in(b, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic send(input bit b, input logic [31:0] instr, input logic [31:0] pc, input vec_t exp);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) offer(b, instr, pc, exp, 1'b0, acc);
        if (!acc) begin
            n_total++;
            $display("FAIL send_timeout: got no accept for pc %h, want accept", pc);
        end
    endtask

    task automatic drain(input bit b);
        int k;
        k = 0;
        while ((b ? exp_b.size() : exp_a.size()) != 0 && k < 50) begin
            @(posedge clk);
            k++;
        end
        #1;
        check(b ? "drain_b" : "drain_a", b ? exp_b.size() : exp_a.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1);
    end

    initial begin
        int   n_acc;
        bit   acc;
        rst_n = 1'b0;
        drive_in(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        drive_in(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        cnt_clr_a = 1'b0; cnt_clr_b = 1'b0;
        aif.out_ready = 1'b1; bif.out_ready = 1'b1;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", aif.in_ready, 1);
        check("rst_out_valid", aif.out_valid, 0);
        check("rst_cnt", cnt_a, 0);
        check("rst_data", {aif.inst_flags, aif.imm, aif.out_pc, aif.illegal}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // back-to-back legal stream
        send(0, 32'h00500093, 32'h100, mk(18, 1, 0, 5, 1, 1, 0, 32'd5, 32'h100));
        check("latency", aif.out_valid, 1);
        send(0, 32'h40208133, 32'h104, mk(28, 2, 1, 2, 1, 1, 1, 32'd0, 32'h104));
        send(0, 32'hFE000EE3, 32'h108, mk(4, 29, 0, 0, 0, 1, 1, 32'hFFFFFFFC, 32'h108));
        send(0, 32'h123450B7, 32'h10C, mk(0, 1, 8, 3, 1, 0, 0, 32'h12345000, 32'h10C));
        send(0, 32'h008000EF, 32'h110, mk(2, 1, 0, 8, 1, 0, 0, 32'd8, 32'h110));
        send(0, 32'h0020A623, 32'h114, mk(17, 12, 1, 2, 0, 1, 1, 32'd12, 32'h114));
        send(0, 32'h4040D193, 32'h118, mk(26, 3, 1, 4, 1, 1, 0, 32'h404, 32'h118));
        send(0, 32'h00000073, 32'h11C, mk(38, 0, 0, 0, 0, 0, 0, 32'd0, 32'h11C));
        send(0, 32'h30029073, 32'h120, mk(40, 0, 5, 0, 0, 1, 0, 32'h300, 32'h120));
        send(0, 32'h00000013, 32'h124, mk(18, 0, 0, 0, 0, 1, 0, 32'd0, 32'h124));
        drain(0);

        // illegal encodings and the counter
        send(0, 32'hFFFFFFFF, 32'h130, mk(-1, 31, 31, 31, 0, 0, 0, 32'd0, 32'h130));
        send(0, 32'h00000000, 32'h134, mk(-1, 0, 0, 0, 0, 0, 0, 32'd0, 32'h134));
        drain(0);
        check("cnt_two", cnt_a, 2);
        send(0, 32'h00002063, 32'h138, mk(-1, 0, 0, 0, 0, 0, 0, 32'd0, 32'h138));
        send(0, 32'h40209133, 32'h13C, mk(-1, 2, 1, 2, 0, 0, 0, 32'd0, 32'h13C));
        drain(0);
        check("cnt_four", cnt_a, 4);
        cnt_clr_a = 1'b1;
        @(posedge clk); #1;
        cnt_clr_a = 1'b0;
        check("cnt_clr", cnt_a, 0);

        // backpressure: two accepted, third held off until the skid drains
        aif.out_ready = 1'b0;
        n_acc = 0;
        offer(0, 32'h00500093, 32'h200, mk(18, 1, 0, 5, 1, 1, 0, 32'd5, 32'h200), 1'b0, acc);
        n_acc += int'(acc);
        offer(0, 32'h40208133, 32'h204, mk(28, 2, 1, 2, 1, 1, 1, 32'd0, 32'h204), 1'b0, acc);
        n_acc += int'(acc);
        offer(0, 32'hFE000EE3, 32'h208, mk(4, 29, 0, 0, 0, 1, 1, 32'hFFFFFFFC, 32'h208), 1'b0, acc);
        n_acc += int'(acc);
        check("bp_accepts", n_acc, 2);
        check("bp_in_ready", aif.in_ready, 0);
        aif.out_ready = 1'b1;
        send(0, 32'hFE000EE3, 32'h208, mk(4, 29, 0, 0, 0, 1, 1, 32'hFFFFFFFC, 32'h208));
        drain(0);

        // flush with both entries full and an illegal input offered
        aif.out_ready = 1'b0;
        send(0, 32'h123450B7, 32'h300, mk(0, 1, 8, 3, 1, 0, 0, 32'h12345000, 32'h300));
        send(0, 32'h008000EF, 32'h304, mk(2, 1, 0, 8, 1, 0, 0, 32'd8, 32'h304));
        offer(0, 32'hFFFFFFFF, 32'h308, 131'd0, 1'b1, acc);
        exp_a.delete();
        check("fl1_out_valid", aif.out_valid, 0);
        check("fl1_in_ready", aif.in_ready, 1);
        check("fl1_cnt", cnt_a, 0);

        // flush while in_ready=1 and the held entry is consumed in the same cycle
        aif.out_ready = 1'b1;
        send(0, 32'h4040D193, 32'h310, mk(26, 3, 1, 4, 1, 1, 0, 32'h404, 32'h310));
        offer(0, 32'hFFFFFFFF, 32'h314, 131'd0, 1'b1, acc);
        check("fl2_out_valid", aif.out_valid, 0);
        check("fl2_cnt", cnt_a, 0);
        check("fl2_consumed", exp_a.size(), 0);
        send(0, 32'h00500093, 32'h318, mk(18, 1, 0, 5, 1, 1, 0, 32'd5, 32'h318));
        drain(0);

        // dut_b: Zicsr disabled and a 2-bit counter
        send(1, 32'h30029073, 32'h400, mk(-1, 0, 5, 0, 0, 0, 0, 32'd0, 32'h400));
        send(1, 32'hFFFFFFFF, 32'h404, mk(-1, 31, 31, 31, 0, 0, 0, 32'd0, 32'h404));
        send(1, 32'h00000073, 32'h408, mk(38, 0, 0, 0, 0, 0, 0, 32'd0, 32'h408));
        drain(1);
        check("b_cnt_two", cnt_b, 2);
        send(1, 32'h00000000, 32'h40C, mk(-1, 0, 0, 0, 0, 0, 0, 32'd0, 32'h40C));
        send(1, 32'h00002063, 32'h410, mk(-1, 0, 0, 0, 0, 0, 0, 32'd0, 32'h410));
        send(1, 32'h40209133, 32'h414, mk(-1, 2, 1, 2, 0, 0, 0, 32'd0, 32'h414));
        drain(1);
        check("b_cnt_sat", cnt_b, 3);
        cnt_clr_b = 1'b1;
        send(1, 32'hFFFFFFFF, 32'h418, mk(-1, 31, 31, 31, 0, 0, 0, 32'd0, 32'h418));
        cnt_clr_b = 1'b0;
        check("b_cnt_clr_wins", cnt_b, 0);
        send(1, 32'h00000000, 32'h41C, mk(-1, 0, 0, 0, 0, 0, 0, 32'd0, 32'h41C));
        drain(1);
        check("b_cnt_after_clr", cnt_b, 1);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
